// File: rtl/bpu_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bpu_update_ctrl
// Purpose  : Sequences all BHT/BTB table writes: an init sweep after reset,
//            then round-robin-arbitrated branch updates through a small FIFO,
//            applying a 2-bit saturating counter read-modify-write per update.
// Revision : 1.0  initial release
// ============================================================================
module bpu_update_ctrl #(
    parameter int IDX_BITS   = 6,
    parameter int ROW_SHIFT  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_pc,
    input  logic        req0_taken,
    input  logic [31:0] req0_target,
    input  logic [31:0] req0_bht_row,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_pc,
    input  logic        req1_taken,
    input  logic [31:0] req1_target,
    input  logic [31:0] req1_bht_row,
    input  logic        flush,
    output logic [63:0] wr_addr,
    output logic        wr_en,
    output logic [31:0] bht_wr_data,
    output logic [31:0] btb_wr_data,
    output logic        init_busy
);

    localparam int                C_AW       = $clog2(FIFO_DEPTH);
    localparam logic [31:0]       C_INIT_ROW = 32'h5555_5555;
    localparam logic [IDX_BITS:0] C_ROWS     = {1'b1, {IDX_BITS{1'b0}}};
    localparam logic [IDX_BITS:0] C_CNT_ONE  = 1;
    localparam logic [C_AW:0]     C_PTR_ONE  = 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [31:0] row;
    } entry_t;

    state_t              state_q, state_d;
    logic [IDX_BITS:0]   init_cnt_q, init_cnt_d;
    entry_t              fifo_q [FIFO_DEPTH];
    entry_t              fifo_d [FIFO_DEPTH];
    logic [C_AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                rr_q, rr_d;
    logic                byp_valid_q, byp_valid_d;
    logic [IDX_BITS-1:0] byp_idx_q, byp_idx_d;
    logic [31:0]         byp_row_q, byp_row_d;
    logic                wr_en_q, wr_en_d;
    logic [63:0]         wr_addr_q, wr_addr_d;
    logic [31:0]         bht_q, bht_d;
    logic [31:0]         btb_q, btb_d;

    logic                w_run, w_empty, w_full;
    logic                w_grant0, w_grant1, w_push, w_pop;
    entry_t              w_in, w_head;
    logic [3:0]          w_slot;
    logic [IDX_BITS-1:0] w_idx;
    logic [31:0]         w_base, w_row_new;
    logic [1:0]          w_cnt, w_cnt_new;
    logic                w_unused;

    assign w_run   = (state_q == ST_RUN);
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[C_AW] != rd_ptr_q[C_AW]) &&
                     (wr_ptr_q[C_AW-1:0] == rd_ptr_q[C_AW-1:0]);

    // rr_q names the requester that wins a tie.
    assign w_grant0 = req0_valid && (!req1_valid || !rr_q);
    assign w_grant1 = req1_valid && (!req0_valid ||  rr_q);

    assign req0_ready = w_run && w_grant0 && !w_full && !flush;
    assign req1_ready = w_run && w_grant1 && !w_full && !flush;
    assign w_push     = req0_ready || req1_ready;
    assign w_pop      = w_run && !w_empty && !flush;

    always_comb begin
        w_in = w_grant0 ? '{pc: req0_pc, taken: req0_taken, target: req0_target, row: req0_bht_row}
                        : '{pc: req1_pc, taken: req1_taken, target: req1_target, row: req1_bht_row};
    end

    assign w_head   = fifo_q[rd_ptr_q[C_AW-1:0]];
    assign w_slot   = w_head.pc[5:2];
    assign w_idx    = w_head.pc[ROW_SHIFT+IDX_BITS-1:ROW_SHIFT];
    assign w_unused = ^w_head.pc[1:0];

    // Consecutive updates to one row would otherwise lose the earlier increment.
    assign w_base = (byp_valid_q && (byp_idx_q == w_idx)) ? byp_row_q : w_head.row;
    assign w_cnt  = w_base[{w_slot, 1'b0} +: 2];

    always_comb begin
        if (w_head.taken) begin
            w_cnt_new = (w_cnt == 2'd3) ? 2'd3 : w_cnt + 2'd1;
        end else begin
            w_cnt_new = (w_cnt == 2'd0) ? 2'd0 : w_cnt - 2'd1;
        end
        w_row_new = w_base;
        w_row_new[{w_slot, 1'b0} +: 2] = w_cnt_new;
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rr_d        = rr_q;
        byp_valid_d = byp_valid_q;
        byp_idx_d   = byp_idx_q;
        byp_row_d   = byp_row_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        bht_d       = bht_q;
        btb_d       = btb_q;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == C_ROWS) begin
                    state_d = ST_RUN;
                end else begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = {{(64-IDX_BITS-ROW_SHIFT){1'b0}},
                                  init_cnt_q[IDX_BITS-1:0], {ROW_SHIFT{1'b0}}};
                    bht_d      = C_INIT_ROW;
                    btb_d      = 32'h0;
                    init_cnt_d = init_cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                if (flush) begin
                    rd_ptr_d    = wr_ptr_q;
                    byp_valid_d = 1'b0;
                end else begin
                    if (w_pop) begin
                        rd_ptr_d    = rd_ptr_q + C_PTR_ONE;
                        wr_en_d     = 1'b1;
                        wr_addr_d   = {w_head.pc[63:ROW_SHIFT], {ROW_SHIFT{1'b0}}};
                        bht_d       = w_row_new;
                        btb_d       = w_head.target;
                        byp_valid_d = 1'b1;
                        byp_idx_d   = w_idx;
                        byp_row_d   = w_row_new;
                    end
                    if (w_push) begin
                        fifo_d[wr_ptr_q[C_AW-1:0]] = w_in;
                        wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                        rr_d     = req0_ready;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rr_q        <= 1'b0;
            byp_valid_q <= 1'b0;
            byp_idx_q   <= '0;
            byp_row_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            bht_q       <= '0;
            btb_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_q        <= rr_d;
            byp_valid_q <= byp_valid_d;
            byp_idx_q   <= byp_idx_d;
            byp_row_q   <= byp_row_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            bht_q       <= bht_d;
            btb_q       <= btb_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign bht_wr_data = bht_q;
    assign btb_wr_data = btb_q;
    assign init_busy   = (state_q == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_bpu_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpu_update_ctrl
// Purpose  : Self-checking bench for bpu_update_ctrl against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bpu_update_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_pc = '0, req1_pc = '0;
    logic        req0_taken = 1'b0, req1_taken = 1'b0;
    logic [31:0] req0_target = '0, req1_target = '0;
    logic [31:0] req0_bht_row = '0, req1_bht_row = '0;
    logic        flush = 1'b0;
    logic [63:0] wr_addr;
    logic        wr_en;
    logic [31:0] bht_wr_data, btb_wr_data;
    logic        init_busy;

    bpu_update_ctrl dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
        .req0_taken(req0_taken), .req0_target(req0_target), .req0_bht_row(req0_bht_row),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
        .req1_taken(req1_taken), .req1_target(req1_target), .req1_bht_row(req1_bht_row),
        .flush(flush), .wr_addr(wr_addr), .wr_en(wr_en),
        .bht_wr_data(bht_wr_data), .btb_wr_data(btb_wr_data), .init_busy(init_busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: update queue, tie-break owner, last-written row.
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] pc;
        bit          taken;
        logic [31:0] tgt;
        logic [31:0] row;
    } ent_t;

    ent_t        m_q[$];
    bit          m_init = 1'b1;
    int          m_n = 0;
    bit          m_rr = 1'b0;
    bit          m_bv = 1'b0;
    int          m_bidx = 0;
    logic [31:0] m_brow = '0;
    bit          e_en = 1'b0, e_all = 1'b0, chk_en = 1'b0;
    logic [63:0] e_addr = '0;
    logic [31:0] e_bht = '0, e_btb = '0;

    // bit 0: requester 0 may enqueue this cycle, bit 1: requester 1.
    function automatic bit [1:0] exp_ready();
        if (m_init || flush || m_q.size() >= 4) return 2'b00;
        if (req0_valid && req1_valid) return m_rr ? 2'b10 : 2'b01;
        return {req1_valid, req0_valid};
    endfunction

    always @(posedge clock) begin : model
        bit [1:0] r;
        e_all = 1'b0;
        if (reset) begin
            m_init = 1'b1; m_n = 0; m_q.delete(); m_rr = 1'b0; m_bv = 1'b0;
            e_en = 1'b0; e_addr = '0; e_bht = '0; e_btb = '0; e_all = 1'b1; chk_en = 1'b1;
        end else if (m_init) begin
            if (m_n < 64) begin
                e_en = 1'b1; e_addr = 64'(m_n) * 64; e_bht = 32'h5555_5555; e_btb = '0;
                m_n++;
            end else begin
                e_en = 1'b0; m_init = 1'b0;
            end
        end else begin
            r = exp_ready();
            if (flush) begin
                m_q.delete(); m_bv = 1'b0; e_en = 1'b0;
            end else begin
                if (m_q.size() > 0) begin
                    ent_t h;
                    int s, idx, c, nc;
                    logic [31:0] base;
                    h    = m_q.pop_front();
                    s    = int'(h.pc[5:2]);
                    idx  = int'((h.pc >> 6) & 64'h3F);
                    base = (m_bv && m_bidx == idx) ? m_brow : h.row;
                    c    = int'((base >> (2 * s)) & 32'h3);
                    nc   = h.taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
                    e_bht  = (base & ~(32'h3 << (2 * s))) | (32'(nc) << (2 * s));
                    e_en   = 1'b1;
                    e_addr = h.pc & ~64'h3F;
                    e_btb  = h.tgt;
                    m_bv = 1'b1; m_bidx = idx; m_brow = e_bht;
                end else begin
                    e_en = 1'b0;
                end
                if (r[0]) m_q.push_back('{req0_pc, req0_taken, req0_target, req0_bht_row});
                if (r[1]) m_q.push_back('{req1_pc, req1_taken, req1_target, req1_bht_row});
                if (r != 2'b00) m_rr = r[0];
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            bit [1:0] r;
            r = exp_ready();
            check("m_wr_en", 64'(wr_en), 64'(e_en));
            check("m_init_busy", 64'(init_busy), 64'(m_init));
            check("m_ready0", 64'(req0_ready), 64'(r[0]));
            check("m_ready1", 64'(req1_ready), 64'(r[1]));
            if (e_en || e_all) begin
                check("m_wr_addr", wr_addr, e_addr);
                check("m_bht", 64'(bht_wr_data), 64'(e_bht));
                check("m_btb", 64'(btb_wr_data), 64'(e_btb));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic send(input int who, input logic [63:0] pc, input bit tk,
                        input logic [31:0] row, input logic [31:0] tgt);
        bit ok = 1'b0;
        @(posedge clock); #1;
        if (who == 0) begin
            req0_valid = 1'b1; req0_pc = pc; req0_taken = tk; req0_bht_row = row; req0_target = tgt;
        end else begin
            req1_valid = 1'b1; req1_pc = pc; req1_taken = tk; req1_bht_row = row; req1_target = tgt;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if ((who == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("send_accepted", 64'(ok), 64'd1);
    endtask

    // Called one cycle after the handshake cycle; write must land one cycle later.
    task automatic expect_write(input string name, input logic [63:0] addr,
                                input logic [31:0] bht, input logic [31:0] btb);
        @(negedge clock);
        check({name, "_early"}, 64'(wr_en), 64'd0);
        @(negedge clock);
        check({name, "_en"}, 64'(wr_en), 64'd1);
        check({name, "_addr"}, wr_addr, addr);
        check({name, "_bht"}, 64'(bht_wr_data), 64'(bht));
        check({name, "_btb"}, 64'(btb_wr_data), 64'(btb));
    endtask

    task automatic flush_pulse();
        @(posedge clock); #1 flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int          cnt;
        logic [63:0] last;
        bit          a0, a1;

        reset = 1'b1; req0_valid = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(init_busy), 64'd1);
        check("rst_addr", wr_addr, 64'd0);
        check("rst_ready0", 64'(req0_ready), 64'd0);
        @(posedge clock); #1 reset = 1'b0; req0_valid = 1'b0;

        cnt = 0; last = '0;
        repeat (70) begin
            @(negedge clock);
            if (wr_en) begin cnt++; last = wr_addr; end
        end
        check("init_writes", 64'(cnt), 64'd64);
        check("init_last_addr", last, 64'hFC0);
        check("init_busy_done", 64'(init_busy), 64'd0);

        // slot 2 of row 0x55555555 goes 1 -> 2
        flush_pulse();
        send(0, 64'h8000_1048, 1'b1, 32'h5555_5555, 32'h8000_2000);
        expect_write("d_basic", 64'h8000_1040, 32'h5555_5565, 32'h8000_2000);
        flush_pulse();
        send(0, 64'h2004, 1'b1, 32'h0000_000C, 32'h1111);
        expect_write("d_sat_hi", 64'h2000, 32'h0000_000C, 32'h1111);
        flush_pulse();
        send(1, 64'h3008, 1'b0, 32'hFFFF_FFCF, 32'h2222);
        expect_write("d_sat_lo", 64'h3000, 32'hFFFF_FFCF, 32'h2222);

        // last winner was requester 1, so requester 0 wins the first tie
        @(posedge clock); #1;
        req0_valid = 1'b1; req0_pc = 64'h4000; req0_taken = 1'b1; req0_bht_row = 32'h0; req0_target = 32'hA0;
        req1_valid = 1'b1; req1_pc = 64'h5044; req1_taken = 1'b0; req1_bht_row = 32'hF; req1_target = 32'hA1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rr_ready0", 64'(req0_ready), 64'(k % 2 == 0));
            check("rr_ready1", 64'(req1_ready), 64'(k % 2 == 1));
            @(posedge clock); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(posedge clock);

        flush_pulse();
        @(posedge clock); #1;
        req0_valid = 1'b1; req0_pc = 64'h1000; req0_taken = 1'b1; req0_bht_row = 32'h5555_5555; req0_target = 32'hB0;
        @(negedge clock);
        check("b2b_ready", 64'(req0_ready), 64'd1);
        @(posedge clock); #1;
        @(posedge clock); #1 req0_valid = 1'b0;
        @(negedge clock);
        check("b2b_first", 64'(bht_wr_data), 64'h5555_5556);
        @(negedge clock);
        check("b2b_second", 64'(bht_wr_data), 64'h5555_5557);

        @(posedge clock); #1;
        req0_valid = 1'b1; req0_pc = 64'h6000; req0_taken = 1'b0; req0_bht_row = 32'hAAAA_AAAA; req0_target = 32'hC0;
        repeat (3) @(posedge clock);
        #1 flush = 1'b1;
        @(negedge clock);
        check("flush_inflight", 64'(wr_en), 64'd1);
        check("flush_no_accept", 64'(req0_ready), 64'd0);
        @(posedge clock); #1 flush = 1'b0;
        @(negedge clock);
        check("flush_dropped", 64'(wr_en), 64'd0);
        check("flush_reaccept", 64'(req0_ready), 64'd1);
        @(posedge clock); #1 req0_valid = 1'b0;
        @(negedge clock);
        check("flush_resume_early", 64'(wr_en), 64'd0);
        @(negedge clock);
        check("flush_resume", 64'(wr_en), 64'd1);

        // reset mid-sweep restarts at row 0
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        repeat (20) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        repeat (70) @(posedge clock);

        a0 = 1'b0; a1 = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clock); #1;
            reset = ($urandom_range(0, 799) == 0);
            flush = ($urandom_range(0, 15) == 0);
            if (!req0_valid || a0) begin
                req0_valid   = ($urandom_range(0, 9) < 6);
                req0_pc      = {$urandom(), 32'($urandom_range(0, 3)) << 6 | 32'($urandom_range(0, 63))};
                req0_taken   = $urandom_range(0, 1);
                req0_bht_row = $urandom();
                req0_target  = $urandom();
            end
            if (!req1_valid || a1) begin
                req1_valid   = ($urandom_range(0, 9) < 6);
                req1_pc      = {$urandom(), 32'($urandom_range(0, 3)) << 6 | 32'($urandom_range(0, 63))};
                req1_taken   = $urandom_range(0, 1);
                req1_bht_row = $urandom();
                req1_target  = $urandom();
            end
            @(negedge clock);
            a0 = req0_valid && req0_ready && !reset;
            a1 = req1_valid && req1_ready && !reset;
        end

        @(posedge clock); #1;
        reset = 1'b0; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
